// File: rtl/ps2_cursor_tracker.sv
// Turns decoded PS/2 mouse packets into a clamped absolute cursor position with button state and click events.
// A one-entry pending buffer absorbs packets that arrive while the pipeline is busy.
module ps2_cursor_tracker #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int START_X     = 320,
  parameter int START_Y     = 240,
  parameter int Y_INVERT    = 1,
  parameter int SPEED_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] mouse_x,
  input  logic [8:0] mouse_y,
  input  logic [2:0] buttons,
  input  logic       packet_ready,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic [2:0] buttons_q,
  output logic       cursor_update,
  output logic       left_click,
  output logic       right_click,
  output logic       middle_click,
  output logic       edge_hit,
  output logic [7:0] drop_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SUM, CLAMP, COMMIT} state_t;

  localparam logic signed [12:0] MAX_X = 13'(SCREEN_W - 1);
  localparam logic signed [12:0] MAX_Y = 13'(SCREEN_H - 1);

  state_t state, state_next;

  logic [8:0]         dx, dy, pend_x, pend_y;
  logic [2:0]         btn, pend_btn;
  logic               pend_valid;
  logic signed [12:0] dx_s, dy_s, sum_x, sum_y, nx, ny;
  logic [9:0]         cx, cy, cx_next, cy_next;
  logic               clamped, clamped_next;
  logic               take_pending;

  assign busy         = (state != IDLE);
  assign take_pending = (state == COMMIT) && pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (packet_ready) state_next = SUM;
      SUM:     state_next = CLAMP;
      CLAMP:   state_next = COMMIT;
      COMMIT:  state_next = pend_valid ? SUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Deltas are sign-extended to 13 bits before scaling so the sum cannot wrap.
  always_comb begin
    dx_s  = $signed({{4{dx[8]}}, dx}) <<< SPEED_SHIFT;
    dy_s  = $signed({{4{dy[8]}}, dy}) <<< SPEED_SHIFT;
    sum_x = $signed({3'b000, cursor_x}) + dx_s;
    sum_y = (Y_INVERT != 0) ? $signed({3'b000, cursor_y}) - dy_s
                            : $signed({3'b000, cursor_y}) + dy_s;
  end

  always_comb begin
    clamped_next = 1'b0;
    cx_next      = nx[9:0];
    cy_next      = ny[9:0];
    if (nx < 0) begin
      cx_next      = '0;
      clamped_next = 1'b1;
    end else if (nx > MAX_X) begin
      cx_next      = MAX_X[9:0];
      clamped_next = 1'b1;
    end
    if (ny < 0) begin
      cy_next      = '0;
      clamped_next = 1'b1;
    end else if (ny > MAX_Y) begin
      cy_next      = MAX_Y[9:0];
      clamped_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx         <= '0;
      dy         <= '0;
      btn        <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_btn   <= '0;
      pend_valid <= 1'b0;
      drop_count <= '0;
      nx         <= '0;
      ny         <= '0;
      cx         <= '0;
      cy         <= '0;
      clamped    <= 1'b0;
    end else begin
      if (state == IDLE && packet_ready) begin
        dx  <= mouse_x;
        dy  <= mouse_y;
        btn <= buttons;
      end else if (take_pending) begin
        dx  <= pend_x;
        dy  <= pend_y;
        btn <= pend_btn;
      end
      // A packet landing on the edge COMMIT drains the buffer refills it without a drop.
      if (state != IDLE && packet_ready) begin
        pend_x     <= mouse_x;
        pend_y     <= mouse_y;
        pend_btn   <= buttons;
        pend_valid <= 1'b1;
        if (pend_valid && !take_pending && drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (take_pending) begin
        pend_valid <= 1'b0;
      end
      if (state == SUM) begin
        nx <= sum_x;
        ny <= sum_y;
      end
      if (state == CLAMP) begin
        cx      <= cx_next;
        cy      <= cy_next;
        clamped <= clamped_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_x      <= 10'(START_X);
      cursor_y      <= 10'(START_Y);
      buttons_q     <= '0;
      cursor_update <= 1'b0;
      left_click    <= 1'b0;
      right_click   <= 1'b0;
      middle_click  <= 1'b0;
      edge_hit      <= 1'b0;
    end else begin
      cursor_update <= 1'b0;
      left_click    <= 1'b0;
      right_click   <= 1'b0;
      middle_click  <= 1'b0;
      edge_hit      <= 1'b0;
      if (state == COMMIT) begin
        cursor_x      <= cx;
        cursor_y      <= cy;
        buttons_q     <= btn;
        cursor_update <= 1'b1;
        left_click    <= btn[0] & ~buttons_q[0];
        right_click   <= btn[1] & ~buttons_q[1];
        middle_click  <= btn[2] & ~buttons_q[2];
        edge_hit      <= clamped;
      end
    end
  end

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Directed bench for ps2_cursor_tracker: default-parameter instance plus a scaled, non-inverted-Y instance.
module tb_ps2_cursor_tracker;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [8:0] mouse_x, mouse_y, m2_x, m2_y;
  logic [2:0] buttons, m2_b;
  logic       packet_ready, pr2;

  logic [9:0] cursor_x, cursor_y, x2, y2;
  logic [2:0] buttons_q, bq2;
  logic       cursor_update, left_click, right_click, middle_click, edge_hit, busy;
  logic       upd2, lc2, rc2, mc2, eh2, busy2;
  logic [7:0] drop_count, drop2;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  ps2_cursor_tracker #(
    .SCREEN_W(640), .SCREEN_H(480), .START_X(320), .START_Y(240),
    .Y_INVERT(1), .SPEED_SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .buttons(buttons), .packet_ready(packet_ready),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .buttons_q(buttons_q),
    .cursor_update(cursor_update), .left_click(left_click),
    .right_click(right_click), .middle_click(middle_click),
    .edge_hit(edge_hit), .drop_count(drop_count), .busy(busy)
  );

  ps2_cursor_tracker #(
    .SCREEN_W(640), .SCREEN_H(480), .START_X(320), .START_Y(240),
    .Y_INVERT(0), .SPEED_SHIFT(2)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .mouse_x(m2_x), .mouse_y(m2_y),
    .buttons(m2_b), .packet_ready(pr2),
    .cursor_x(x2), .cursor_y(y2), .buttons_q(bq2),
    .cursor_update(upd2), .left_click(lc2),
    .right_click(rc2), .middle_click(mc2),
    .edge_hit(eh2), .drop_count(drop2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Sends one packet to dut and returns at the negedge where cursor_update is seen (or after a bound).
  task automatic send1(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] b,
                       output int lat);
    @(negedge clk);
    mouse_x = dx; mouse_y = dy; buttons = b; packet_ready = 1'b1;
    @(negedge clk);
    packet_ready = 1'b0;
    lat = 0;
    while (!cursor_update && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("update_seen", cursor_update, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, ups;
    logic [8:0] dxs [4];
    logic       exp_lc [4], exp_rc [4];
    logic [2:0] bseq [4];

    rst_n = 1'b0; rst2_n = 1'b0;
    mouse_x = '0; mouse_y = '0; buttons = '0; packet_ready = 1'b0;
    m2_x = '0; m2_y = '0; m2_b = '0; pr2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: reset state
    chk("rst_x", cursor_x, 320);
    chk("rst_y", cursor_y, 240);
    chk("rst_btn", buttons_q, 0);
    chk("rst_upd", cursor_update, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);

    // 2: basic move, latency, single-cycle pulse
    send1(9'd5, 9'd5, 3'b000, lat);
    chk("t2_lat", lat, 3);
    chk("t2_x", cursor_x, 325);
    chk("t2_y", cursor_y, 235);
    chk("t2_edge", edge_hit, 0);
    @(negedge clk);
    chk("t2_upd_pulse", cursor_update, 0);

    // 3: clamp at both X edges
    send1(9'h101, 9'h087, 3'b000, lat);  // dx=-255, dy=+135
    chk("t3a_x", cursor_x, 70);
    chk("t3a_y", cursor_y, 100);
    send1(9'h1BC, 9'h000, 3'b000, lat);  // dx=-68
    chk("t3b_x", cursor_x, 2);
    chk("t3b_edge", edge_hit, 0);
    send1(9'h1F9, 9'h000, 3'b000, lat);  // dx=-7
    chk("t3c_x", cursor_x, 0);
    chk("t3c_edge", edge_hit, 1);
    for (int i = 0; i < 4; i++) begin
      send1(9'h0FF, 9'h000, 3'b000, lat);
      chk($sformatf("t3d_x%0d", i), cursor_x, (i == 0) ? 255 : (i == 1) ? 510 : 639);
      chk($sformatf("t3d_edge%0d", i), edge_hit, (i >= 2) ? 1 : 0);
    end
    chk("t3_y", cursor_y, 100);

    // 4: click pulses on press edges only
    bseq[0] = 3'b001; bseq[1] = 3'b001; bseq[2] = 3'b011; bseq[3] = 3'b000;
    exp_lc[0] = 1; exp_lc[1] = 0; exp_lc[2] = 0; exp_lc[3] = 0;
    exp_rc[0] = 0; exp_rc[1] = 0; exp_rc[2] = 1; exp_rc[3] = 0;
    for (int i = 0; i < 4; i++) begin
      send1(9'h000, 9'h000, bseq[i], lat);
      chk($sformatf("t4_lc%0d", i), left_click, exp_lc[i]);
      chk($sformatf("t4_rc%0d", i), right_click, exp_rc[i]);
      chk($sformatf("t4_mc%0d", i), middle_click, 0);
      chk($sformatf("t4_bq%0d", i), buttons_q, bseq[i]);
    end
    chk("t4_x", cursor_x, 639);

    // 5: back-to-back packets, one dropped
    send1(9'h101, 9'h000, 3'b000, lat);  // 639-255
    chk("t5_start_x", cursor_x, 384);
    @(negedge clk); mouse_x = 9'd1; mouse_y = '0; buttons = '0; packet_ready = 1'b1;
    @(negedge clk); mouse_x = 9'd2;
    @(negedge clk); mouse_x = 9'd4;
    @(negedge clk); packet_ready = 1'b0;
    chk("t5_busy", busy, 1);
    ups = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (cursor_update) ups++;
    end
    chk("t5_updates", ups, 2);
    chk("t5_x", cursor_x, 389);
    chk("t5_y", cursor_y, 100);
    chk("t5_drop", drop_count, 1);
    chk("t5_idle", busy, 0);

    // 6: scaled, non-inverted Y instance, then reset mid-packet
    @(negedge clk); m2_x = 9'd3; m2_y = 9'h1FE; m2_b = '0; pr2 = 1'b1;
    @(negedge clk); pr2 = 1'b0;
    lat = 0;
    while (!upd2 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_lat", lat, 3);
    chk("t6_x", x2, 332);
    chk("t6_y", y2, 232);
    @(negedge clk); m2_x = 9'd5; m2_y = 9'd5; pr2 = 1'b1;
    @(negedge clk); pr2 = 1'b0;
    chk("t6_busy_sum", busy2, 1);
    rst2_n = 1'b0;
    #1;
    chk("t6_rst_x", x2, 320);
    chk("t6_rst_y", y2, 240);
    chk("t6_rst_busy", busy2, 0);
    ups = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (upd2) ups++;
    end
    rst2_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (upd2) ups++;
    end
    chk("t6_no_update", ups, 0);
    chk("t6_final_x", x2, 320);
    chk("t6_final_busy", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
